debounce_fsm: RTL and testbench
===============================

// Module: debounce_fsm
// PURPOSE
//  Debounces one raw mechanical input (button or switch) into a clean level, plus a one-cycle tick on each
//  debounced 0->1 transition. Sits directly upstream of rising_edge_detect_mealy in the MMIO misc path.
//  db_level drives that detector's level input. The input is registered first (optionally through a 2-FF
//  synchronizer), then a 4-state FSM with a down-counter filters bounces.
// PARAMETERS
//  STABLE_CNT  2_000_000  cycles the input must hold before the debounced state changes (20 ms @ 100 MHz); >= 1
//  CNT_W       21         counter width; requires 2**CNT_W > STABLE_CNT-1
// PORTS
//  clk       in   1  system clock; everything is on its rising edge
//  reset     in   1  synchronous, active-high reset
//  sw        in   1  raw, bouncy, asynchronous input
//  db_level  out  1  debounced level
//  db_tick   out  1  one-cycle pulse on a debounced 0->1 transition
// BEHAVIOUR
//  - Reset (synchronous, active-high): state=ZERO, cnt=0, sync/sample FFs=0, db_level=0, db_tick=0.
//    Reset takes effect at the next clk edge and overrides everything, including mid-count WAIT1 or WAIT0.
//  - sw_s: the sampled input (sync chain output, or a single register when DB_SYNC_EN is undefined).
//  - States: ZERO, WAIT1, ONE, WAIT0. N = STABLE_CNT.
//  - ZERO:  sw_s=1 -> WAIT1, cnt <= N-1; else stay.
//  - WAIT1: sw_s=0 -> ZERO (bounce rejected, cnt ignored).
//           sw_s=1 & cnt==0 -> ONE. sw_s=1 & cnt!=0 -> cnt <= cnt-1.
//  - ONE:   sw_s=0 -> WAIT0, cnt <= N-1; else stay.
//  - WAIT0: sw_s=1 -> ONE (bounce rejected).
//           sw_s=0 & cnt==0 -> ZERO. sw_s=0 & cnt!=0 -> cnt <= cnt-1.
//  - Illegal or undefined state -> ZERO.
//  - db_level = (state==ONE) | (state==WAIT0). Moore, glitch-free.
//  - db_tick = (state==WAIT1) & sw_s & (cnt==0). Mealy: high during the cycle that ends in the WAIT1->ONE edge.
//    Exactly one cycle per accepted rise. Never asserted on falls.
//  - Latency: define edge 0 as the first edge at which sw_s=1 in ZERO.
//    db_level goes high after edge N. db_tick is high between edges N-1 and N.
//    Falls are symmetric: db_level goes low after edge N from the first sw_s=0 in ONE.
//  - N=1 is legal: WAIT1/WAIT0 last exactly one cycle.
//  - The counter never wraps: it is only loaded in ZERO/ONE and stops decrementing at 0 on a state exit.
// CONFIGURATION
//  - DB_SYNC_EN defined: sw passes through a 2-FF synchronizer (both FFs reset to 0) before sw_s.
//    Adds 2 cycles to every latency above. Required when sw comes from a package pin.
//  - DB_SYNC_EN undefined: sw_s is a single register of sw. Use only for inputs already synchronous to clk.
//  - The FSM and outputs are identical in both builds apart from that latency.
// TESTING (STABLE_CNT=4, CNT_W=3; bench runs both DB_SYNC_EN builds, latencies shifted +2 when defined)
//  1. Reset held 3 cycles, sw=1 throughout -> db_level=0, db_tick=0 during reset; after release db_level rises at edge 4.
//  2. Clean press: sw 0->1 held 10 cycles -> db_tick=1 for exactly 1 cycle (edge 3-4); db_level=1 from edge 4.
//  3. Bounce on press: sw 1,0,1,1,0 for 1 cycle each, then 1 -> no db_tick; db_level rises 4 edges after the final rise.
//  4. Release with bounce: from ONE, sw 0,1,0 then held 0 -> db_level stays 1 until 4 edges after the final fall; no tick.
//  5. Reset mid-WAIT1 (cnt=2) -> next edge: state ZERO, db_level=0; with sw still 1, a full 4-edge requalification follows.
//  6. STABLE_CNT=1 with sw toggling every 2 cycles -> db_level follows sw delayed 1 edge (+sample); one tick per rise.

Source files
------------

// File: rtl/debounce_fsm.sv
// debounce_fsm: debounces one raw input into db_level plus a one-cycle db_tick on each accepted rise.
// Optional build macro DB_SYNC_EN inserts a 2-FF synchronizer ahead of the sample register (+2 cycles).
module debounce_fsm #(
    parameter int unsigned STABLE_CNT = 2_000_000,
    parameter int unsigned CNT_W      = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(STABLE_CNT - 1);

    logic sw_s;
    logic sample_d;

`ifdef DB_SYNC_EN
    logic sync_0;
    logic sync_1;

    // Two flops to settle metastability before the value reaches the sample register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= sw;
            sync_1 <= sync_0;
        end
    end

    assign sample_d = sync_1;
`else
    assign sample_d = sw;
`endif

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s <= 1'b0;
        end else begin
            sw_s <= sample_d;
        end
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        db_tick    = 1'b0;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_next = ZERO;
                end else if (cnt_zero) begin
                    state_next = ONE;
                    db_tick    = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = LOAD;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_next = ONE;
                end else if (cnt_zero) begin
                    state_next = ZERO;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ZERO;
            end
        endcase
    end

    // Level decodes straight from the state register, so it cannot glitch.
    assign db_level = (state == ONE) || (state == WAIT0);

endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed checks of debounce_fsm with STABLE_CNT=4 and STABLE_CNT=1 instances.
// Expected latencies shift by 2 cycles when DB_SYNC_EN is defined.
module tb_debounce_fsm;

`ifdef DB_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int NVEC = 37;

    logic clk;
    logic reset;
    logic sw;
    logic sw1;
    logic db_level;
    logic db_tick;
    logic db_level1;
    logic db_tick1;

    int checks = 0;
    int errors = 0;
    int ticks1 = 0;

    typedef struct {
        logic sw;
        logic level;
        logic tick;
    } vec_t;

    vec_t  tbl [NVEC];
    string sw_str;
    string lvl_str;
    string tck_str;

    debounce_fsm #(.STABLE_CNT(4), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    debounce_fsm #(.STABLE_CNT(1), .CNT_W(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw1),
        .db_level (db_level1),
        .db_tick  (db_tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge to sample.
    task automatic step(input logic r, input logic s, input logic s1);
        @(posedge clk);
        #1;
        reset = r;
        sw    = s;
        sw1   = s1;
        @(negedge clk);
    endtask

    task automatic go_idle();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check("idle_level", db_level, 0);
        check("idle_level1", db_level1, 0);
    endtask

    function automatic logic pat(input int j);
        return (j >= 0) && (j < 16) && ((j % 4) < 2);
    endfunction

    initial begin
        int src;
        reset = 1'b1;
        sw    = 1'b1;
        sw1   = 1'b0;

        // Reset held with sw high, then a full qualification after release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("rst_level[%0d]", i), db_level, 0);
            check($sformatf("rst_tick[%0d]", i), db_tick, 0);
        end
        for (int i = 0; i < 10 + LAT; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("t1_level[%0d]", i), db_level, 32'(i >= 6 + LAT));
            check($sformatf("t1_tick[%0d]", i), db_tick, 32'(i == 5 + LAT));
        end

        // Clean press, bouncy release, bouncy press (expected values for the unsynchronized latency).
        sw_str  = {"00", "1111111111", "0100000000", "10110", "1111111111"};
        lvl_str = {"00000000", "111111111111", "0000000000000", "1111"};
        tck_str = {"0000000", "1", "000000000000", "000000000000", "1", "0000"};
        if (sw_str.len() != NVEC || lvl_str.len() != NVEC || tck_str.len() != NVEC) begin
            $display("FAIL table_len: sw %0d lvl %0d tck %0d", sw_str.len(), lvl_str.len(), tck_str.len());
            $fatal(1, "bad table");
        end
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].sw    = (sw_str.getc(i) == "1");
            tbl[i].level = (lvl_str.getc(i) == "1");
            tbl[i].tick  = (tck_str.getc(i) == "1");
        end

        go_idle();
        for (int i = 0; i < NVEC + LAT; i++) begin
            src = i - LAT;
            step(1'b0, tbl[(i < NVEC) ? i : NVEC - 1].sw, 1'b0);
            check($sformatf("tbl_level[%0d]", i), db_level, (src >= 0) ? 32'(tbl[src].level) : 0);
            check($sformatf("tbl_tick[%0d]", i), db_tick, (src >= 0) ? 32'(tbl[src].tick) : 0);
        end

        // Reset while WAIT1 holds cnt=2, then requalify from scratch with sw still high.
        go_idle();
        for (int j = 0; j <= 3 + LAT; j++) begin
            step((j == 3 + LAT), 1'b1, 1'b0);
            check($sformatf("t5_pre_level[%0d]", j), db_level, 0);
            check($sformatf("t5_pre_tick[%0d]", j), db_tick, 0);
        end
        for (int r = 0; r < 10 + LAT; r++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("t5_level[%0d]", r), db_level, 32'(r >= 6 + LAT));
            check($sformatf("t5_tick[%0d]", r), db_tick, 32'(r == 5 + LAT));
        end

        // STABLE_CNT=1 instance with sw toggling every 2 cycles.
        go_idle();
        for (int k = 0; k < 20 + LAT; k++) begin
            step(1'b0, 1'b0, pat(k));
            if (db_tick1) ticks1++;
            check($sformatf("t6_level[%0d]", k), db_level1, 32'(pat(k - 3 - LAT)));
            check($sformatf("t6_tick[%0d]", k), db_tick1, 32'(pat(k - 2 - LAT) && !pat(k - 3 - LAT)));
        end
        check("t6_tick_count", ticks1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
